mmss_timer: RTL and testbench

- Minutes:seconds BCD timer that sits directly downstream of the 1 Hz tick generator and consumes its single-cycle `tick` pulse.
- Counts up (stopwatch) or down (countdown from a loaded preset) under start/stop/clear/load pulse controls.
- Presents four BCD digits to the seven-segment display stage.
- Flags countdown completion and up-count wrap.

---
 rtl/mmss_timer.sv | 164 ++++++++++++++++
 tb/tb_mmss_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer.sv
// mmss_timer
// Minutes:seconds BCD timer driven by the 1 Hz tick pulse. Counts up as a
// stopwatch or down from a loaded preset, under start/stop/clear/load pulses.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   tick     one-cycle pulse from the tick generator
//   start    pulse: begin/resume counting (IDLE/PAUSE -> RUN)
//   stop     pulse: pause counting (RUN -> PAUSE)
//   clear    pulse: zero the digits, return to IDLE
//   load     pulse: load preset (not while RUN)
//   dir      0 = count up, 1 = count down (sampled at each step)
//   preset   BCD preset {M1,M0,S1,S0}
//   digits   BCD time {M1,M0,S1,S0}
//   state    IDLE=00, RUN=01, PAUSE=10, DONE=11
//   running  high while RUN
//   done     high while DONE
//   wrap     one-cycle pulse on an up-count 59:59 -> 00:00

module mmss_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic        dir,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic [1:0]  state,
    output logic        running,
    output logic        done,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t      cur;
    logic [7:0]  prescale;

    logic        preset_ok;
    logic        is_zero;
    logic        at_div;
    logic [15:0] up_val;
    logic [15:0] dn_val;
    logic        up_wraps;

    assign state   = cur;
    assign running = (cur == RUN);
    assign done    = (cur == DONE);

    assign preset_ok = (preset[15:12] <= 4'd5) && (preset[11:8] <= 4'd9) &&
                       (preset[7:4]   <= 4'd5) && (preset[3:0]  <= 4'd9);
    assign is_zero   = (digits == 16'h0000);
    // The TICK_DIV-th counted tick is the one seen while the prescaler
    // already holds TICK_DIV-1.
    assign at_div    = (prescale == 8'(TICK_DIV - 1));
    assign up_wraps  = (digits == 16'h5959);

    // BCD increment with carries S0(9) -> S1(5) -> M0(9) -> M1(5).
    always_comb begin
        up_val = digits;
        if (digits[3:0] != 4'd9) begin
            up_val[3:0] = digits[3:0] + 4'd1;
        end else begin
            up_val[3:0] = 4'd0;
            if (digits[7:4] != 4'd5) begin
                up_val[7:4] = digits[7:4] + 4'd1;
            end else begin
                up_val[7:4] = 4'd0;
                if (digits[11:8] != 4'd9) begin
                    up_val[11:8] = digits[11:8] + 4'd1;
                end else begin
                    up_val[11:8] = 4'd0;
                    if (digits[15:12] != 4'd5)
                        up_val[15:12] = digits[15:12] + 4'd1;
                    else
                        up_val[15:12] = 4'd0;
                end
            end
        end
    end

    // BCD decrement with mirrored borrows. Only used when digits != 0000,
    // so the M1 nibble never underflows.
    always_comb begin
        dn_val = digits;
        if (digits[3:0] != 4'd0) begin
            dn_val[3:0] = digits[3:0] - 4'd1;
        end else begin
            dn_val[3:0] = 4'd9;
            if (digits[7:4] != 4'd0) begin
                dn_val[7:4] = digits[7:4] - 4'd1;
            end else begin
                dn_val[7:4] = 4'd5;
                if (digits[11:8] != 4'd0) begin
                    dn_val[11:8] = digits[11:8] - 4'd1;
                end else begin
                    dn_val[11:8] = 4'd9;
                    if (digits[15:12] != 4'd0)
                        dn_val[15:12] = digits[15:12] - 4'd1;
                    else
                        dn_val[15:12] = 4'd0;
                end
            end
        end
    end

    // Control chain in priority order. A control that has no effect in the
    // current state (load in RUN or with a bad preset, stop outside RUN,
    // start where not allowed) falls through to the next one, so it never
    // swallows a tick. An effective stop does take the whole cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits   <= 16'h0000;
            cur      <= IDLE;
            prescale <= 8'd0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                digits   <= 16'h0000;
                cur      <= IDLE;
                prescale <= 8'd0;
            end else if (load && (cur != RUN) && preset_ok) begin
                digits   <= preset;
                cur      <= IDLE;
                prescale <= 8'd0;
            end else if (stop && (cur == RUN)) begin
                cur <= PAUSE;
            end else if (start && ((cur == IDLE) || (cur == PAUSE)) &&
                         !(dir && is_zero)) begin
                cur <= RUN;
            end else if (tick && (cur == RUN)) begin
                if (at_div) begin
                    prescale <= 8'd0;
                    if (!dir) begin
                        digits <= up_val;
                        wrap   <= up_wraps;
                    end else if (is_zero) begin
                        // Direction flipped to down while already at zero.
                        cur <= DONE;
                    end else begin
                        digits <= dn_val;
                        if (dn_val == 16'h0000)
                            cur <= DONE;
                    end
                end else begin
                    prescale <= prescale + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// tb_mmss_timer
// Drives two timers (TICK_DIV=1 and TICK_DIV=3) with the same stimulus.
// A reference model keeps the time as plain elapsed seconds and pushes the
// expected outputs into a queue; a monitor pops and compares every cycle.

module tb_mmss_timer;

    logic        clk = 1'b0;
    logic        rst, tick, start, stop, clear, load, dir;
    logic [15:0] preset;

    logic [15:0] digits_a, digits_b;
    logic [1:0]  state_a, state_b;
    logic        running_a, running_b, done_a, done_b, wrap_a, wrap_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] dg0;
        logic [15:0] dg1;
        logic [1:0]  st0;
        logic [1:0]  st1;
        logic        wr0;
        logic        wr1;
    } expect_t;

    expect_t sbq[$];

    // Model state: time in seconds, state code, prescaler count, wrap flag.
    int       m_secs[2];
    int       m_st[2];
    int       m_pre[2];
    bit       m_wr[2];
    const int DIVS[2] = '{1, 3};

    always #5 clk = ~clk;

    mmss_timer #(.TICK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .dir(dir), .preset(preset),
        .digits(digits_a), .state(state_a), .running(running_a),
        .done(done_a), .wrap(wrap_a)
    );

    mmss_timer #(.TICK_DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .load(load), .dir(dir), .preset(preset),
        .digits(digits_b), .state(state_b), .running(running_b),
        .done(done_b), .wrap(wrap_b)
    );

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit bcd_valid(input logic [15:0] p);
        return (p[15:12] <= 5) && (p[11:8] <= 9) && (p[7:4] <= 5) && (p[3:0] <= 9);
    endfunction

    function automatic int bcd_to_secs(input logic [15:0] p);
        return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 +
               int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of the reference model (states: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE).
    task automatic model_cycle(input int i);
        m_wr[i] = 1'b0;
        if (rst || clear) begin
            m_secs[i] = 0; m_st[i] = 0; m_pre[i] = 0;
        end else if (load && m_st[i] != 1 && bcd_valid(preset)) begin
            m_secs[i] = bcd_to_secs(preset); m_st[i] = 0; m_pre[i] = 0;
        end else if (stop && m_st[i] == 1) begin
            m_st[i] = 2;
        end else if (start && (m_st[i] == 0 || m_st[i] == 2) && !(dir && m_secs[i] == 0)) begin
            m_st[i] = 1;
        end else if (tick && m_st[i] == 1) begin
            m_pre[i]++;
            if (m_pre[i] == DIVS[i]) begin
                m_pre[i] = 0;
                if (!dir) begin
                    m_wr[i]   = (m_secs[i] == 3599);
                    m_secs[i] = (m_secs[i] + 1) % 3600;
                end else begin
                    if (m_secs[i] > 0) m_secs[i]--;
                    if (m_secs[i] == 0) m_st[i] = 3;
                end
            end
        end
    endtask

    // Drive one cycle of pulses, predict the result, and return just after
    // the monitor has compared it.
    task automatic applyStimulus(input bit tk, input bit sa, input bit so,
                                 input bit cl, input bit ld);
        expect_t e;
        @(negedge clk);
        tick = tk; start = sa; stop = so; clear = cl; load = ld;
        model_cycle(0);
        model_cycle(1);
        e.dg0 = to_bcd(m_secs[0]); e.dg1 = to_bcd(m_secs[1]);
        e.st0 = 2'(m_st[0]);       e.st1 = 2'(m_st[1]);
        e.wr0 = m_wr[0];           e.wr1 = m_wr[1];
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0);
    endtask

    // Monitor: every clock the timer presents a new result; compare it with
    // the oldest prediction.
    always begin
        expect_t e;
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("div1 digits",  digits_a,  e.dg0);
            checkOutput("div1 state",   state_a,   e.st0);
            checkOutput("div1 running", running_a, (e.st0 == 2'd1));
            checkOutput("div1 done",    done_a,    (e.st0 == 2'd3));
            checkOutput("div1 wrap",    wrap_a,    e.wr0);
            checkOutput("div3 digits",  digits_b,  e.dg1);
            checkOutput("div3 state",   state_b,   e.st1);
            checkOutput("div3 running", running_b, (e.st1 == 2'd1));
            checkOutput("div3 done",    done_b,    (e.st1 == 2'd3));
            checkOutput("div3 wrap",    wrap_b,    e.wr1);
        end
    end

    function automatic logic [15:0] rand_preset();
        case ($urandom_range(0, 3))
            0: return 16'($urandom());
            1: return 16'h5955 + 16'($urandom_range(0, 4));
            2: return 16'($urandom_range(1, 3));
            default: return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        endcase
    endfunction

    initial begin
        int r;
        rst = 1'b1; tick = 0; start = 0; stop = 0; clear = 0; load = 0;
        dir = 1'b0; preset = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            m_secs[i] = 0; m_st[i] = 0; m_pre[i] = 0; m_wr[i] = 0;
        end

        idle_cycles(2);
        rst = 1'b0;
        checkOutput("reset digits", digits_a, 16'h0000);
        checkOutput("reset state",  state_a,  2'd0);

        // Reset held for two cycles in the middle of a run at 12:34.
        preset = 16'h1234;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(1);
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        checkOutput("rst mid-run digits", digits_a, 16'h0000);
        checkOutput("rst mid-run state",  state_a,  2'd0);
        checkOutput("rst mid-run done",   done_a,   1'b0);
        checkOutput("rst mid-run wrap",   wrap_a,   1'b0);

        // Stopwatch: 61 steps, then stop and ignore further ticks.
        dir = 1'b0;
        applyStimulus(0, 1, 0, 0, 0);
        ticks(61);
        checkOutput("up 61 digits", digits_a, 16'h0101);
        applyStimulus(0, 0, 1, 0, 0);
        ticks(5);
        checkOutput("paused digits", digits_a, 16'h0101);
        checkOutput("paused state",  state_a,  2'd2);

        // Countdown from 00:02 to DONE.
        applyStimulus(0, 0, 0, 1, 0);
        preset = 16'h0002; dir = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(1);
        checkOutput("down first digits", digits_a, 16'h0001);
        ticks(1);
        checkOutput("down zero digits", digits_a, 16'h0000);
        checkOutput("down zero state",  state_a,  2'd3);
        checkOutput("down zero done",   done_a,   1'b1);
        ticks(2);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("done hold state", state_a, 2'd3);

        // Up-count wrap 59:58 -> 59:59 -> 00:00.
        preset = 16'h5958; dir = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(1);
        checkOutput("pre-wrap digits", digits_a, 16'h5959);
        ticks(1);
        checkOutput("wrap digits", digits_a, 16'h0000);
        checkOutput("wrap pulse",  wrap_a,   1'b1);
        checkOutput("wrap state",  state_a,  2'd1);
        idle_cycles(1);
        checkOutput("wrap one cycle", wrap_a, 1'b0);

        // Invalid preset, load during RUN, stop coincident with tick.
        ticks(2);
        applyStimulus(0, 0, 1, 0, 0);
        preset = 16'h0060;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("bad preset digits", digits_a, 16'h0002);
        applyStimulus(0, 1, 0, 0, 0);
        preset = 16'h0100;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("load in run digits", digits_a, 16'h0002);
        checkOutput("load in run state",  state_a,  2'd1);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("stop+tick digits", digits_a, 16'h0002);
        checkOutput("stop+tick state",  state_a,  2'd2);

        // Divide-by-3 prescaler survives a pause.
        applyStimulus(0, 0, 0, 1, 0);
        dir = 1'b0;
        applyStimulus(0, 1, 0, 0, 0);
        ticks(2);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        ticks(5);
        checkOutput("div3 seven ticks", digits_b, 16'h0002);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("div3 clear digits", digits_b, 16'h0000);
        checkOutput("div3 clear state",  state_b,  2'd0);

        // Randomized traffic: at most one control pulse per cycle, and only
        // stop may coincide with a tick.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 2) dir = ~dir;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                applyStimulus(0, 0, 0, 1, 0);
            end else if (r < 7) begin
                preset = rand_preset();
                applyStimulus(0, 0, 0, 0, 1);
            end else if (r < 10) begin
                applyStimulus(1'($urandom_range(0, 1)), 0, 1, 0, 0);
            end else if (r < 17) begin
                applyStimulus(0, 1, 0, 0, 0);
            end else begin
                applyStimulus(($urandom_range(0, 9) < 7), 0, 0, 0, 0);
            end
        end
        rst = 1'b0;

        @(posedge clk);
        #3;
        checkOutput("scoreboard drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
